// File: rtl/lamp_sequence_monitor.sv
// rtl/lamp_sequence_monitor.sv - checks red/yellow/green lamp order, latches faults, counts cycles
module lamp_sequence_monitor #(
    parameter int MAX_HOLD = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [0:2]       light,
    input  logic             clear,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [0:2]       expected
);

    localparam int HW = $clog2(MAX_HOLD + 1) + 1;

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] YELLOW = 3'b010;
    localparam logic [0:2] GREEN  = 3'b001;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_ORDER   = 2'b10;
    localparam logic [1:0] CODE_STUCK   = 2'b11;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t        state;
    logic [0:2]    prev;
    logic [HW-1:0] hold;

    function automatic logic is_one_hot(input logic [0:2] s);
        return (s == RED) || (s == YELLOW) || (s == GREEN);
    endfunction

    // Successor of a one-hot code; anything else maps to 000 so it never matches.
    function automatic logic [0:2] successor(input logic [0:2] s);
        logic [0:2] n;
        n = 3'b000;
        case (s)
            RED:     n = YELLOW;
            YELLOW:  n = GREEN;
            GREEN:   n = RED;
            default: n = 3'b000;
        endcase
        return n;
    endfunction

    // Single FSM: reset beats clear, clear beats the sample taken on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= SYNC;
            prev        <= 3'b000;
            hold        <= '0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= CODE_NONE;
            cycle_count <= '0;
            expected    <= 3'b000;
        end else if (clear) begin
            state      <= SYNC;
            prev       <= 3'b000;
            hold       <= '0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            expected   <= 3'b000;
        end else begin
            case (state)
                SYNC: begin
                    // Power-up garbage from the controller is silently skipped.
                    if (is_one_hot(light)) begin
                        state    <= TRACK;
                        prev     <= light;
                        hold     <= HW'(1);
                        locked   <= 1'b1;
                        expected <= successor(light);
                    end
                end
                TRACK: begin
                    if (!is_one_hot(light)) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= CODE_ILLEGAL;
                        locked     <= 1'b0;
                        expected   <= 3'b000;
                    end else if (light == prev) begin
                        // hold+1 > MAX_HOLD is the same as hold >= MAX_HOLD.
                        if (hold >= HW'(MAX_HOLD)) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= CODE_STUCK;
                            locked     <= 1'b0;
                            expected   <= 3'b000;
                        end else if (hold != {HW{1'b1}}) begin
                            hold <= hold + HW'(1);
                        end
                    end else if (light == successor(prev)) begin
                        prev     <= light;
                        hold     <= HW'(1);
                        expected <= successor(light);
                        if (light == RED) begin
                            cycle_count <= cycle_count + CNT_W'(1);
                        end
                    end else begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= CODE_ORDER;
                        locked     <= 1'b0;
                        expected   <= 3'b000;
                    end
                end
                FAULT: begin
                    // Latched until clear or reset; light is ignored here.
                    state <= FAULT;
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// tb/tb_lamp_sequence_monitor.sv - directed self-checking bench for lamp_sequence_monitor
module tb_lamp_sequence_monitor;

    logic       clock;
    logic       reset_n;
    logic [0:2] light;
    logic       clear;

    logic       locked_a, fault_a;
    logic [1:0] code_a;
    logic [7:0] count_a;
    logic [0:2] exp_a;

    logic       locked_b, fault_b;
    logic [1:0] code_b;
    logic [7:0] count_b;
    logic [0:2] exp_b;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    lamp_sequence_monitor #(.MAX_HOLD(1), .CNT_W(8)) u_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .light       (light),
        .clear       (clear),
        .locked      (locked_a),
        .fault       (fault_a),
        .fault_code  (code_a),
        .cycle_count (count_a),
        .expected    (exp_a)
    );

    lamp_sequence_monitor #(.MAX_HOLD(4), .CNT_W(8)) u_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .light       (light),
        .clear       (clear),
        .locked      (locked_b),
        .fault       (fault_b),
        .fault_code  (code_b),
        .cycle_count (count_b),
        .expected    (exp_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic [0:2] l, input logic c);
        light = l;
        clear = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        light   = 3'b000;
        clear   = 1'b0;
        #1;

        // Reset state
        step(3'b101, 1'b0);
        step(3'b100, 1'b0);
        chk("rst_locked", locked_a, 0);
        chk("rst_fault", fault_a, 0);
        chk("rst_code", code_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_expected", exp_a, 3'b000);

        // Nominal stream
        reset_n = 1'b1;
        step(3'b010, 1'b0);
        chk("nom_lock", locked_a, 1);
        chk("nom_exp0", exp_a, 3'b001);
        for (int i = 0; i < 3; i++) begin
            step(3'b001, 1'b0);
            chk("nom_exp_g", exp_a, 3'b100);
            step(3'b100, 1'b0);
            chk("nom_exp_r", exp_a, 3'b010);
            chk("nom_count", count_a, i + 1);
            step(3'b010, 1'b0);
            chk("nom_exp_y", exp_a, 3'b001);
        end
        chk("nom_fault", fault_a, 0);
        chk("nom_count3", count_a, 3);

        // Power-up garbage
        reset_n = 1'b0;
        step(3'b000, 1'b0);
        reset_n = 1'b1;
        step(3'b000, 1'b0);
        chk("garb_lock0", locked_a, 0);
        step(3'b111, 1'b0);
        chk("garb_lock1", locked_a, 0);
        step(3'b110, 1'b0);
        chk("garb_lock2", locked_a, 0);
        chk("garb_fault", fault_a, 0);
        step(3'b100, 1'b0);
        chk("garb_locked", locked_a, 1);
        chk("garb_exp", exp_a, 3'b010);

        // Stuck lamp: 100 already sampled once; four more identical samples
        step(3'b100, 1'b0);
        chk("stuck_a_fault", fault_a, 1);
        chk("stuck_a_code", code_a, 2'b11);
        step(3'b100, 1'b0);
        step(3'b100, 1'b0);
        chk("stuck_b_four", fault_b, 0);
        chk("stuck_b_lock", locked_b, 1);
        step(3'b100, 1'b0);
        chk("stuck_b_fault", fault_b, 1);
        chk("stuck_b_code", code_b, 2'b11);
        chk("stuck_b_lock0", locked_b, 0);

        // Bad transition and clear
        step(3'b000, 1'b1);
        chk("clr_fault", fault_a, 0);
        chk("clr_code", code_a, 0);
        step(3'b100, 1'b0);
        step(3'b010, 1'b0);
        step(3'b001, 1'b0);
        step(3'b100, 1'b0);
        chk("bad_count_pre", count_a, 1);
        step(3'b001, 1'b0);
        chk("bad_fault", fault_a, 1);
        chk("bad_code", code_a, 2'b10);
        chk("bad_exp", exp_a, 3'b000);
        step(3'b010, 1'b0);
        step(3'b001, 1'b0);
        step(3'b100, 1'b0);
        chk("bad_frozen", count_a, 1);
        chk("bad_code_kept", code_a, 2'b10);
        step(3'b100, 1'b1);
        chk("bad_clr_fault", fault_a, 0);
        chk("bad_clr_lock", locked_a, 0);
        chk("bad_clr_count", count_a, 1);
        step(3'b001, 1'b0);
        chk("relock", locked_a, 1);
        chk("relock_exp", exp_a, 3'b100);

        // Illegal code, then collision with clear
        step(3'b011, 1'b0);
        chk("ill_code", code_a, 2'b01);
        chk("ill_fault", fault_a, 1);
        step(3'b000, 1'b1);
        step(3'b100, 1'b0);
        chk("coll_pre_lock", locked_a, 1);
        step(3'b011, 1'b1);
        chk("coll_fault", fault_a, 0);
        chk("coll_lock", locked_a, 0);
        chk("coll_exp", exp_a, 3'b000);
        step(3'b010, 1'b0);
        chk("coll_relock", locked_a, 1);
        chk("coll_relock_exp", exp_a, 3'b001);

        // Wrap: 256 full cycles from a zeroed counter
        reset_n = 1'b0;
        step(3'b000, 1'b0);
        reset_n = 1'b1;
        step(3'b100, 1'b0);
        chk("wrap_start", count_a, 0);
        for (int i = 0; i < 256; i++) begin
            step(3'b010, 1'b0);
            step(3'b001, 1'b0);
            step(3'b100, 1'b0);
            if (i == 254) chk("wrap_255", count_a, 255);
        end
        chk("wrap_zero", count_a, 0);
        chk("wrap_fault", fault_a, 0);
        chk("wrap_lock", locked_a, 1);

        // Reset while in FAULT
        step(3'b001, 1'b0);
        chk("pre_rst_fault", fault_a, 1);
        reset_n = 1'b0;
        step(3'b010, 1'b0);
        chk("frst_fault", fault_a, 0);
        chk("frst_code", code_a, 0);
        chk("frst_lock", locked_a, 0);
        chk("frst_count", count_a, 0);
        chk("frst_exp", exp_a, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
